// File: rtl/bcd_fsd_counter.sv
// Two-digit BCD up/down counter with run/pause control, load, clear and
// terminal-count pulse. Drives 15-segment active-low patterns for both digits.

// Single-digit BCD to 15-segment decoder (active-low, optional blanking).
module bcd_fsd_seg (
   input  logic [3:0]  digit_i,
   input  logic        blank_i,
   output logic [14:0] seg_o
);

   // Map the BCD digit to its segment pattern; blank overrides the digit.
   always_comb begin
      seg_o = 15'h7FFF;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = 15'h01FF;
            4'd1:    seg_o = 15'h4FFF;
            4'd2:    seg_o = 15'h127F;
            4'd3:    seg_o = 15'h067F;
            4'd4:    seg_o = 15'h4C7F;
            4'd5:    seg_o = 15'h247F;
            4'd6:    seg_o = 15'h207F;
            4'd7:    seg_o = 15'h0FFF;
            4'd8:    seg_o = 15'h007F;
            4'd9:    seg_o = 15'h047F;
            default: seg_o = 15'h7FFF;
         endcase
      end
   end

endmodule

module bcd_fsd_counter #(
   parameter int MAX_COUNT = 99,
   parameter bit BLANK_LZ  = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_stop,
   input  logic        clr,
   input  logic        up_dn,
   input  logic        load,
   input  logic [3:0]  load_u,
   input  logic [3:0]  load_t,
   output logic [3:0]  cnt_u,
   output logic [3:0]  cnt_t,
   output logic [14:0] fsd_u,
   output logic [14:0] fsd_t,
   output logic        running,
   output logic        tc
);

   // Wrap target split into BCD digits once, at elaboration.
   localparam logic [3:0] MAX_U = 4'(MAX_COUNT % 10);
   localparam logic [3:0] MAX_T = 4'(MAX_COUNT / 10);
   localparam logic [7:0] MAX_B = 8'(MAX_COUNT);

   typedef enum logic {
      PAUSE = 1'b0,
      RUN   = 1'b1
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] cnt_u_q, cnt_u_d;
   logic [3:0] cnt_t_q, cnt_t_d;
   logic       tc_q, tc_d;

   logic [7:0] load_bin;
   logic       load_ok;
   logic       at_max;
   logic       at_zero;

   // Load is only honoured for a legal BCD value within the count range.
   assign load_bin = (8'(load_t) * 8'd10) + 8'(load_u);
   assign load_ok  = (load_u <= 4'd9) && (load_t <= 4'd9) && (load_bin <= MAX_B);
   assign at_max   = (cnt_t_q == MAX_T) && (cnt_u_q == MAX_U);
   assign at_zero  = (cnt_t_q == 4'd0) && (cnt_u_q == 4'd0);

   // State register; async reset parks the counter in PAUSE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= PAUSE;
      else        state_q <= state_d;
   end

   // Next state: clear forces PAUSE and swallows a same-cycle start_stop.
   always_comb begin
      state_d = state_q;
      if (clr)             state_d = PAUSE;
      else if (start_stop) state_d = (state_q == RUN) ? PAUSE : RUN;
   end

   // FSM output: running follows the state register directly.
   always_comb begin
      running = (state_q == RUN);
   end

   // Count and terminal-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_u_q <= 4'd0;
         cnt_t_q <= 4'd0;
         tc_q    <= 1'b0;
      end else begin
         cnt_u_q <= cnt_u_d;
         cnt_t_q <= cnt_t_d;
         tc_q    <= tc_d;
      end
   end

   // Next count: clear, then load (which also suppresses stepping), then step while running.
   always_comb begin
      cnt_u_d = cnt_u_q;
      cnt_t_d = cnt_t_q;
      tc_d    = 1'b0;
      if (clr) begin
         cnt_u_d = 4'd0;
         cnt_t_d = 4'd0;
      end else if (load) begin
         if (load_ok) begin
            cnt_u_d = load_u;
            cnt_t_d = load_t;
         end
      end else if (state_q == RUN) begin
         if (up_dn) begin
            if (at_max) begin
               cnt_u_d = 4'd0;
               cnt_t_d = 4'd0;
               tc_d    = 1'b1;
            end else if (cnt_u_q == 4'd9) begin
               cnt_u_d = 4'd0;
               cnt_t_d = cnt_t_q + 4'd1;
            end else begin
               cnt_u_d = cnt_u_q + 4'd1;
            end
         end else begin
            if (at_zero) begin
               cnt_u_d = MAX_U;
               cnt_t_d = MAX_T;
               tc_d    = 1'b1;
            end else if (cnt_u_q == 4'd0) begin
               cnt_u_d = 4'd9;
               cnt_t_d = cnt_t_q - 4'd1;
            end else begin
               cnt_u_d = cnt_u_q - 4'd1;
            end
         end
      end
   end

   assign cnt_u = cnt_u_q;
   assign cnt_t = cnt_t_q;
   assign tc    = tc_q;

   // Decoders sit straight on the count registers so segments track the count with no extra latency.
   bcd_fsd_seg u_seg_u (
      .digit_i (cnt_u_q),
      .blank_i (1'b0),
      .seg_o   (fsd_u)
   );

   bcd_fsd_seg u_seg_t (
      .digit_i (cnt_t_q),
      .blank_i (BLANK_LZ && (cnt_t_q == 4'd0)),
      .seg_o   (fsd_t)
   );

endmodule

// File: tb/tb_bcd_fsd_counter.sv
// Bench for bcd_fsd_counter: three instances (MAX 99, MAX 59, MAX 99 with
// leading-zero blanking) share stimulus and are each tracked by an integer model.
module tb_bcd_fsd_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_stop = 1'b0, clr = 1'b0, up_dn = 1'b1, load = 1'b0;
   logic [3:0] load_u = 4'd0, load_t = 4'd0;

   logic [3:0]  cu [3];
   logic [3:0]  ct [3];
   logic [14:0] fu [3];
   logic [14:0] ft [3];
   logic        rn [3];
   logic        tcv[3];

   int vectors = 0;
   int errors  = 0;

   // Behavioural model: plain integer value, run flag and tc per instance.
   int mmax [3] = '{99, 59, 99};
   bit mblk [3] = '{1'b0, 1'b0, 1'b1};
   int mv   [3];
   bit mrun [3];
   bit mtc  [3];

   always #5 clk = ~clk;

   bcd_fsd_counter #(.MAX_COUNT(99), .BLANK_LZ(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr), .up_dn(up_dn),
      .load(load), .load_u(load_u), .load_t(load_t), .cnt_u(cu[0]), .cnt_t(ct[0]),
      .fsd_u(fu[0]), .fsd_t(ft[0]), .running(rn[0]), .tc(tcv[0]));

   bcd_fsd_counter #(.MAX_COUNT(59), .BLANK_LZ(1'b0)) dut59 (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr), .up_dn(up_dn),
      .load(load), .load_u(load_u), .load_t(load_t), .cnt_u(cu[1]), .cnt_t(ct[1]),
      .fsd_u(fu[1]), .fsd_t(ft[1]), .running(rn[1]), .tc(tcv[1]));

   bcd_fsd_counter #(.MAX_COUNT(99), .BLANK_LZ(1'b1)) dutb (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clr(clr), .up_dn(up_dn),
      .load(load), .load_u(load_u), .load_t(load_t), .cnt_u(cu[2]), .cnt_t(ct[2]),
      .fsd_u(fu[2]), .fsd_t(ft[2]), .running(rn[2]), .tc(tcv[2]));

   function automatic logic [14:0] seg_of(input int d);
      case (d)
         0: return 15'h01FF;  1: return 15'h4FFF;  2: return 15'h127F;
         3: return 15'h067F;  4: return 15'h4C7F;  5: return 15'h247F;
         6: return 15'h207F;  7: return 15'h0FFF;  8: return 15'h007F;
         9: return 15'h047F;
         default: return 15'h7FFF;
      endcase
   endfunction

   // Expected {tens, units, fsd_t, fsd_u, running, tc} for instance i.
   function automatic logic [39:0] exp_vec(input int i);
      int t, u;
      logic [14:0] st;
      t  = mv[i] / 10;
      u  = mv[i] % 10;
      st = (mblk[i] && t == 0) ? 15'h7FFF : seg_of(t);
      return {4'(t), 4'(u), st, seg_of(u), mrun[i], mtc[i]};
   endfunction

   function automatic logic [39:0] obs_vec(input int i);
      return {ct[i], cu[i], ft[i], fu[i], rn[i], tcv[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mv[i] = 0; mrun[i] = 1'b0; mtc[i] = 1'b0;
      end
   endtask

   // Model one clock edge from the values that were on the inputs.
   task automatic model_edge(input bit ss, input bit c, input bit ud, input bit ld,
                             input int lu, input int lt);
      for (int i = 0; i < 3; i++) begin
         mtc[i] = 1'b0;
         if (c) begin
            mv[i] = 0; mrun[i] = 1'b0;
         end else begin
            if (ld) begin
               if (lu <= 9 && lt <= 9 && (10 * lt + lu) <= mmax[i]) mv[i] = 10 * lt + lu;
            end else if (mrun[i]) begin
               if (ud) begin
                  if (mv[i] == mmax[i]) begin mv[i] = 0; mtc[i] = 1'b1; end
                  else mv[i] = mv[i] + 1;
               end else begin
                  if (mv[i] == 0) begin mv[i] = mmax[i]; mtc[i] = 1'b1; end
                  else mv[i] = mv[i] - 1;
               end
            end
            if (ss) mrun[i] = !mrun[i];
         end
      end
   endtask

   // Drive one cycle of inputs at the falling edge, clock it, update the model.
   task automatic step(input bit ss, input bit c, input bit ud, input bit ld,
                       input logic [3:0] lu, input logic [3:0] lt);
      @(negedge clk);
      start_stop = ss; clr = c; up_dn = ud; load = ld; load_u = lu; load_t = lt;
      @(posedge clk);
      model_edge(ss, c, ud, ld, int'(lu), int'(lt));
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL reset inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
         end
      end
      vectors++;
      if (ft[2] !== 15'h7FFF || ft[0] !== 15'h01FF) begin
         errors++;
         $display("FAIL reset_blank got %h/%h want 7fff/01ff", ft[2], ft[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_count_up();
      step(1, 0, 1, 0, 0, 0);
      for (int n = 0; n < 13; n++) begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL count_up step%0d inst%0d got %h want %h", n, i, obs_vec(i), exp_vec(i));
            end
         end
         if (n < 12) step(0, 0, 1, 0, 0, 0);
      end
      vectors++;
      if (ft[0] !== 15'h4FFF || fu[0] !== 15'h127F || rn[0] !== 1'b1) begin
         errors++;
         $display("FAIL count_up_12 got %h %h run=%b want 4fff 127f run=1", ft[0], fu[0], rn[0]);
      end
   endtask

   task automatic test_wrap_up();
      logic [7:0] want_cnt [4];
      logic       want_tc  [4];
      want_cnt = '{8'h98, 8'h99, 8'h00, 8'h01};
      want_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
      step(0, 0, 1, 1, 4'd8, 4'd9);
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL wrap_up step%0d inst%0d got %h want %h", n, i, obs_vec(i), exp_vec(i));
            end
         end
         vectors++;
         if ({ct[0], cu[0]} !== want_cnt[n] || tcv[0] !== want_tc[n]) begin
            errors++;
            $display("FAIL wrap_up_seq step%0d got %h tc=%b want %h tc=%b",
                     n, {ct[0], cu[0]}, tcv[0], want_cnt[n], want_tc[n]);
         end
         if (n < 3) step(0, 0, 1, 0, 0, 0);
      end
   endtask

   task automatic test_wrap_down();
      step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3; n++) begin
         step(0, 0, 0, 0, 0, 0);
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL wrap_down step%0d inst%0d got %h want %h", n, i, obs_vec(i), exp_vec(i));
            end
         end
         if (n == 0) begin
            vectors++;
            if ({ct[0], cu[0], tcv[0]} !== {8'h99, 1'b1} || {ct[1], cu[1], tcv[1]} !== {8'h59, 1'b1}) begin
               errors++;
               $display("FAIL wrap_down_max got %h%h/%h%h want 99+tc/59+tc",
                        {ct[0], cu[0]}, tcv[0], {ct[1], cu[1]}, tcv[1]);
            end
         end
      end
   endtask

   task automatic test_load_rules();
      logic [7:0] before59;
      step(0, 0, 1, 1, 4'hA, 4'd1);
      step(0, 0, 1, 1, 4'd5, 4'd7);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL load_rules inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
         end
      end
      before59 = 8'(((mv[1] / 10) << 4) | (mv[1] % 10));
      vectors++;
      if ({ct[1], cu[1]} !== before59 || {ct[0], cu[0]} !== 8'h75) begin
         errors++;
         $display("FAIL load_range got %h/%h want %h/75", {ct[1], cu[1]}, {ct[0], cu[0]}, before59);
      end
      step(1, 1, 1, 1, 4'd3, 4'd3);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs_vec(i) !== exp_vec(i) || {ct[i], cu[i], rn[i]} !== 9'h0) begin
            errors++;
            $display("FAIL clr_priority inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
         end
      end
   endtask

   task automatic test_async_reset();
      step(1, 0, 1, 1, 4'd7, 4'd3);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 4'd7, 4'd3);
      vectors++;
      if ({ct[0], cu[0]} !== 8'h37 || rn[0] !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got %h run=%b want 37 run=1", {ct[0], cu[0]}, rn[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs_vec(i) !== exp_vec(i)) begin
            errors++;
            $display("FAIL async_reset inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_blank();
      step(0, 0, 1, 1, 4'd5, 4'd0);
      vectors++;
      if (ft[2] !== 15'h7FFF || fu[2] !== 15'h247F || ft[0] !== 15'h01FF) begin
         errors++;
         $display("FAIL blank_lz got %h %h (%h) want 7fff 247f (01ff)", ft[2], fu[2], ft[0]);
      end
      step(0, 0, 1, 1, 4'd5, 4'd1);
      vectors++;
      if (ft[2] !== 15'h4FFF) begin
         errors++;
         $display("FAIL blank_nonzero got %h want 4fff", ft[2]);
      end
   endtask

   task automatic test_random();
      bit ss, c, ud, ld;
      for (int n = 0; n < 400; n++) begin
         ss = ($urandom_range(0, 9) == 0);
         c  = ($urandom_range(0, 29) == 0);
         ld = ($urandom_range(0, 14) == 0);
         ud = ($urandom_range(0, 3) != 0) ^ (n >= 200);
         step(ss, c, ud, ld, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
         for (int i = 0; i < 3; i++) begin
            vectors++;
            if (obs_vec(i) !== exp_vec(i)) begin
               errors++;
               $display("FAIL random cyc%0d inst%0d got %h want %h", n, i, obs_vec(i), exp_vec(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_load_rules();
      test_async_reset();
      test_blank();
      step(1, 0, 1, 0, 0, 0);
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/bcd_fsd_counter.md
Name: bcd_fsd_counter

Overview:
- Two-digit BCD up/down counter with run/pause control. Drives the units and tens 15-bit segment patterns (fsd_u, fsd_t) that the display scan stage multiplexes onto the panel.
- Clocked by the slow count clock (clk_cnt) from the frequency divider. One increment or decrement per enabled clk edge.
- Also exposes raw BCD digits and a terminal-count pulse for cascading or timers.

Parameters:
- MAX_COUNT, 99: highest count value, 1..99. Up-count wraps to 0 after it; down-count wraps from 0 to it.
- BLANK_LZ, 0: when 1, the tens digit is blanked while cnt_t==0.

Ports:
- clk  input  1  count clock (clk_cnt domain)
- rst_n  input  1  asynchronous active-low reset
- start_stop  input  1  one-cycle pulse; toggles RUN/PAUSE
- clr  input  1  one-cycle pulse; count to 00, state to PAUSE
- up_dn  input  1  1 = count up, 0 = count down; sampled every edge
- load  input  1  one-cycle pulse; load load_t:load_u
- load_u  input  4  BCD units value to load
- load_t  input  4  BCD tens value to load
- cnt_u  output  4  current units digit, BCD
- cnt_t  output  4  current tens digit, BCD
- fsd_u  output  15  units segment pattern, active-low
- fsd_t  output  15  tens segment pattern, active-low
- running  output  1  1 while in RUN
- tc  output  1  one-cycle pulse on wrap

Behaviour:
- Reset (async, rst_n=0):
  - cnt_u=0, cnt_t=0, state=PAUSE, running=0, tc=0.
  - fsd_u=fsd_t=0x01FF (digit 0). With BLANK_LZ=1, fsd_t=0x7FFF.
- FSM has two states, PAUSE and RUN. start_stop=1 toggles the state on the next edge. running is registered and equals (state==RUN).
- Per-edge priority:
  1. clr: count to 00, state to PAUSE, tc=0. A start_stop in the same cycle is ignored.
  2. load: accepted only if load_u<=9, load_t<=9 and 10*load_t+load_u<=MAX_COUNT. Otherwise the count is unchanged. The state is unaffected, start_stop still toggles, and no count step occurs that cycle.
  3. RUN: step by ±1 according to up_dn.
  4. PAUSE: hold.
- Up-count:
  - Units 9→0 with tens+1.
  - At value==MAX_COUNT, next value is 00 and tc=1 for exactly one cycle.
- Down-count:
  - Units 0→9 with tens-1.
  - At 00, next value is MAX_COUNT and tc=1 for one cycle.
- tc is registered and asserted the same edge as the wrapped value. It is 0 on all other cycles.
- Arithmetic is pure BCD per digit; there is never a non-BCD value on cnt_u/cnt_t.
- Segment encoding:
  - Bit map: [14]=a [13]=b [12]=c [11]=d [10]=e [9]=f [8]=g1 [7]=g2 [6:1]=h,i,j,k,l,m (always off) [0]=dp (always off). 0 = lit.
  - Digits 0..9 = 0x01FF, 0x4FFF, 0x127F, 0x067F, 0x4C7F, 0x247F, 0x207F, 0x0FFF, 0x007F, 0x047F.
  - Blank = 0x7FFF.
- fsd_u/fsd_t are combinational decodes of the cnt registers, so they change on the same edge as the count (zero added latency).
- Reset mid-count overrides everything immediately, without waiting for a clock.

Test Plan:
- Reset, then start_stop pulse, up_dn=1, 12 edges → running=1, count 12, fsd_t=0x4FFF, fsd_u=0x127F, tc=0 throughout.
- load 9,8 (98) while RUN, up_dn=1 → 98 at load edge, then 99, then 00 with tc=1 for one cycle, then 01 with tc=0.
- From 00 in RUN, up_dn=0 → next value 99 with tc=1. Repeat with MAX_COUNT=59 → 59.
- load_u=0xA, or load 7,5 with MAX_COUNT=59 → count unchanged. Same-cycle clr+start_stop+load → count 00, state PAUSE.
- In RUN at 37, assert rst_n=0 between edges → outputs 00/PAUSE immediately, without a clock. BLANK_LZ=1 at count 05 → fsd_t=0x7FFF, fsd_u=0x247F.
